// File: rtl/mem_bist.sv
// -----------------------------------------------------------------------------
// mem_bist
//
// Built-in self test for a single-port word memory with a valid/ready request
// interface. A run writes the pattern P(a) = a ^ SEED to every address, then
// reads every address back and compares it with the same pattern. Mismatches
// are counted (saturating), and the address of the first mismatch is kept.
//
// Build option:
//   MEM_BIST_INV_PASS_EN  when defined, two further phases follow the first
//                         read pass: write ~P(a) everywhere, then read back
//                         and compare against ~P(a).
//
// Ports:
//   clk_i        rising-edge clock for all logic
//   rst_i        synchronous, active-low reset
//   start_i      begins a run when sampled high in IDLE or DONE
//   busy_o       a run is in progress
//   done_o       run finished; held until the next start or reset
//   pass_o       run result, meaningful while done_o is high
//   err_count_o  saturating count of read mismatches
//   fail_addr_o  address of the first mismatch
//   addr_o       memory request address
//   wdata_o      memory write data
//   wr_rd_o      1 = write request, 0 = read request
//   valid_o      memory request valid
//   ready_i      memory accepts the request (read data valid the same cycle)
//   rdata_i      memory read data
// -----------------------------------------------------------------------------
module mem_bist #(
    parameter int              WIDTH      = 16,
    parameter int              DEPTH      = 64,
    parameter int              ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(16'hA5A5)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH+1:0] err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i
);

`ifdef MEM_BIST_INV_PASS_EN
    typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR0, RD0, DONE} state_t;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // Wide enough to zero-extend the address to the data width even if the
    // address happens to be the wider of the two.
    localparam int EXT_WIDTH = (WIDTH > ADDR_WIDTH) ? WIDTH : ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH+1:0]   err_count_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic                    pass_q;

    logic [EXT_WIDTH-1:0]    addr_ext;
    logic [WIDTH-1:0]        pattern;
    logic [WIDTH-1:0]        rd_expect;
    logic                    handshake;
    logic                    rd_phase;
    logic                    final_read;
    logic                    last_read;
    logic                    mismatch;
    logic                    start_accept;
    logic                    addr_last;

    assign addr_ext = EXT_WIDTH'(addr_q);
    assign pattern  = addr_ext[WIDTH-1:0] ^ SEED;
    assign addr_last = (addr_q == LAST_ADDR);

    // Read-compare bookkeeping. The final read phase is the one whose last
    // handshake ends the run; the inverse phase compares against ~P(a).
`ifdef MEM_BIST_INV_PASS_EN
    assign rd_phase   = (state_q == RD0) || (state_q == RD1);
    assign final_read = (state_q == RD1);
    assign rd_expect  = (state_q == RD1) ? ~pattern : pattern;
`else
    assign rd_phase   = (state_q == RD0);
    assign final_read = (state_q == RD0);
    assign rd_expect  = pattern;
`endif

    assign handshake    = valid_o && ready_i;
    assign mismatch     = handshake && rd_phase && (rdata_i != rd_expect);
    assign last_read    = handshake && final_read && addr_last;
    assign start_accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    // State, address and result registers. A start clears the results of
    // the previous run; otherwise mismatches update the counter and the
    // first-failure address, and the last read latches the verdict.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            err_count_q <= '0;
            fail_addr_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (start_accept) begin
                err_count_q <= '0;
                fail_addr_q <= '0;
                pass_q      <= 1'b0;
            end else begin
                if (mismatch) begin
                    if (err_count_q != '1) begin
                        err_count_q <= err_count_q + 1'b1;
                    end
                    if (err_count_q == '0) begin
                        fail_addr_q <= addr_q;
                    end
                end
                // The final compare has not reached the counter yet, so it
                // is folded in here directly.
                if (last_read) begin
                    pass_q <= (err_count_q == '0) && !mismatch;
                end
            end
        end
    end

    // Next-state and request outputs. The address only moves on a
    // handshake, so requests stay stable while the memory stalls, and the
    // address returns to 0 at every phase boundary.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_o = 1'b0;
        wr_rd_o = 1'b0;
        wdata_o = '0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done_o = (state_q == DONE);
                if (start_i) begin
                    state_d = WR0;
                    addr_d  = '0;
                end
            end
            WR0: begin
                valid_o = 1'b1;
                wr_rd_o = 1'b1;
                wdata_o = pattern;
                busy_o  = 1'b1;
                if (ready_i) begin
                    if (addr_last) begin
                        state_d = RD0;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            RD0: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                if (ready_i) begin
                    if (addr_last) begin
`ifdef MEM_BIST_INV_PASS_EN
                        state_d = WR1;
`else
                        state_d = DONE;
`endif
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`ifdef MEM_BIST_INV_PASS_EN
            WR1: begin
                valid_o = 1'b1;
                wr_rd_o = 1'b1;
                wdata_o = ~pattern;
                busy_o  = 1'b1;
                if (ready_i) begin
                    if (addr_last) begin
                        state_d = RD1;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            RD1: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                if (ready_i) begin
                    if (addr_last) begin
                        state_d = DONE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign addr_o      = addr_q;
    assign err_count_o = err_count_q;
    assign fail_addr_o = fail_addr_q;
    assign pass_o      = pass_q;

endmodule

// File: tb/tb_mem_bist.sv
// -----------------------------------------------------------------------------
// tb_mem_bist
//
// Bench for mem_bist with default parameters. A behavioural memory answers
// the request interface (always ready, never ready, or two wait cycles per
// request) and can plant read faults. Every expected transfer of a run is
// queued when the run is started and popped as the DUT performs it.
// Honours MEM_BIST_INV_PASS_EN for the number of phases.
// -----------------------------------------------------------------------------
module tb_mem_bist;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int PH = 4;
`else
    localparam int PH = 2;
`endif

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, pass_o;
    logic [AW+1:0] err_count_o;
    logic [AW-1:0] fail_addr_o;
    logic [AW-1:0] addr_o;
    logic [15:0]   wdata_o;
    logic          wr_rd_o, valid_o;
    logic          ready_i;
    logic [15:0]   rdata_i;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;
    int fault_mode = 0;
    int wait_cnt = 0;
    bit mon_en = 1'b0;
    int cyc;
    int n;

    logic [15:0]   mem [0:DEPTH-1];
    xfer_t         exp_q [$];

    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [15:0]   hold_wdata;
    logic          hold_wr;

    mem_bist dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .err_count_o (err_count_o),
        .fail_addr_o (fail_addr_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .wr_rd_o     (wr_rd_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .rdata_i     (rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory acceptance: mode 0 never ready, mode 2 inserts two wait
    // cycles before each acceptance, otherwise always ready.
    always_comb begin
        case (ready_mode)
            0:       ready_i = 1'b0;
            2:       ready_i = (wait_cnt >= 2);
            default: ready_i = 1'b1;
        endcase
    end

    always @(posedge clk) begin
        if (valid_o && !ready_i) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (valid_o && ready_i && wr_rd_o) mem[addr_o] <= wdata_o;
    end

    // Read data with planted faults: mode 1 sticks bit 0 high at address 5,
    // mode 2 flips bit 0 at every address.
    always_comb begin
        rdata_i = mem[addr_o];
        if (fault_mode == 1 && addr_o == AW'(5)) rdata_i[0] = 1'b1;
        if (fault_mode == 2) rdata_i[0] = ~mem[addr_o][0];
    end

    // Monitor, sampled mid-cycle: stalled requests must not change, and each
    // handshake must match the next queued transfer.
    always @(negedge clk) begin
        if (!mon_en || !rst_i) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                checkOutput("hold_valid", 32'(valid_o), 32'(1));
                checkOutput("hold_addr", 32'(addr_o), 32'(hold_addr));
                checkOutput("hold_wdata", 32'(wdata_o), 32'(hold_wdata));
                checkOutput("hold_wr", 32'(wr_rd_o), 32'(hold_wr));
            end
            hold_pend  <= valid_o && !ready_i;
            hold_addr  <= addr_o;
            hold_wdata <= wdata_o;
            hold_wr    <= wr_rd_o;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("xfer_unexpected", 32'(exp_q.size()), 32'(1));
                end else begin
                    checkOutput("xfer_wr", 32'(wr_rd_o), 32'(exp_q[0].wr));
                    checkOutput("xfer_addr", 32'(addr_o), 32'(exp_q[0].addr));
                    if (exp_q[0].wr) checkOutput("xfer_wdata", 32'(wdata_o), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One complete run: queue the expected transfers, start, wait for done
    // within a bound, optionally pulse start at a given cycle of the run.
    task automatic applyStimulus(input int rmode, input int fmode, input int pulse_at, output int cycles);
        ready_mode = rmode;
        fault_mode = fmode;
        exp_q.delete();
        for (int ph = 0; ph < PH; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                exp_q.push_back('{wr: (ph % 2 == 0), addr: AW'(a),
                                  data: (ph >= 2) ? ~pat(a) : pat(a)});
            end
        end
        mon_en  = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        checkOutput("start_done_clr", 32'(done_o), 32'(0));
        checkOutput("start_err_clr", 32'(err_count_o), 32'(0));
        checkOutput("start_fail_clr", 32'(fail_addr_o), 32'(0));
        checkOutput("start_valid", 32'(valid_o), 32'(1));
        checkOutput("start_addr", 32'(addr_o), 32'(0));
        checkOutput("start_busy", 32'(busy_o), 32'(1));
        cycles = 0;
        while (!done_o && cycles < 8 * PH * DEPTH) begin
            start_i = (cycles == pulse_at);
            @(posedge clk); #1;
            start_i = 1'b0;
            cycles++;
        end
        checkOutput("done_reached", 32'(done_o), 32'(1));
        checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));
        mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_held", 32'(done_o), 32'(1));
        checkOutput("idle_busy", 32'(busy_o), 32'(0));
        checkOutput("idle_valid", 32'(valid_o), 32'(0));
    endtask

    initial begin
        // Reset dominates a simultaneous start.
        rst_i   = 1'b0;
        start_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid_o), 32'(0));
        checkOutput("rst_wr_rd", 32'(wr_rd_o), 32'(0));
        checkOutput("rst_busy", 32'(busy_o), 32'(0));
        checkOutput("rst_done", 32'(done_o), 32'(0));
        checkOutput("rst_pass", 32'(pass_o), 32'(0));
        checkOutput("rst_addr", 32'(addr_o), 32'(0));
        checkOutput("rst_wdata", 32'(wdata_o), 32'(0));
        checkOutput("rst_err", 32'(err_count_o), 32'(0));
        checkOutput("rst_fail", 32'(fail_addr_o), 32'(0));
        start_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_rst", 32'(busy_o), 32'(0));

        $display("[TB] run: ideal memory");
        applyStimulus(1, 0, -1, cyc);
        checkOutput("ideal_cycles", 32'(cyc), 32'(PH * DEPTH));
        checkOutput("ideal_pass", 32'(pass_o), 32'(1));
        checkOutput("ideal_err", 32'(err_count_o), 32'(0));
        checkOutput("ideal_fail", 32'(fail_addr_o), 32'(0));

        $display("[TB] run: two wait cycles per request");
        applyStimulus(2, 0, -1, cyc);
        checkOutput("wait_cycles", 32'(cyc), 32'(3 * PH * DEPTH));
        checkOutput("wait_pass", 32'(pass_o), 32'(1));
        checkOutput("wait_err", 32'(err_count_o), 32'(0));

        $display("[TB] run: bit0 stuck high at address 5");
        applyStimulus(1, 1, -1, cyc);
        checkOutput("stuck_cycles", 32'(cyc), 32'(PH * DEPTH));
        checkOutput("stuck_pass", 32'(pass_o), 32'(0));
        checkOutput("stuck_err", 32'(err_count_o), 32'(1));
        checkOutput("stuck_fail", 32'(fail_addr_o), 32'(5));

        $display("[TB] run: restart from DONE with start pulsed during RD0");
        applyStimulus(1, 0, DEPTH + 10, cyc);
        checkOutput("pulse_cycles", 32'(cyc), 32'(PH * DEPTH));
        checkOutput("pulse_pass", 32'(pass_o), 32'(1));
        checkOutput("pulse_err", 32'(err_count_o), 32'(0));
        checkOutput("pulse_fail", 32'(fail_addr_o), 32'(0));

        $display("[TB] run: every address faulty");
        applyStimulus(1, 2, -1, cyc);
        checkOutput("all_err", 32'(err_count_o), 32'((PH / 2) * DEPTH));
        checkOutput("all_fail", 32'(fail_addr_o), 32'(0));
        checkOutput("all_pass", 32'(pass_o), 32'(0));

        $display("[TB] run: reset during stalled write to address 20");
        ready_mode = 1;
        fault_mode = 0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 0;
        while (addr_o != AW'(20) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_reach20", 32'(addr_o), 32'(20));
        ready_mode = 0;
        rst_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_valid", 32'(valid_o), 32'(0));
        checkOutput("abort_busy", 32'(busy_o), 32'(0));
        checkOutput("abort_done", 32'(done_o), 32'(0));
        checkOutput("abort_addr", 32'(addr_o), 32'(0));
        rst_i = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 0, -1, cyc);
        checkOutput("rerun_cycles", 32'(cyc), 32'(PH * DEPTH));
        checkOutput("rerun_pass", 32'(pass_o), 32'(1));
        checkOutput("rerun_err", 32'(err_count_o), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 Parameter WIDTH, default 16, data word width; SHALL match the downstream memory's data width.
REQ-002 Parameter DEPTH, default 64, number of words tested.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 Parameter SEED, default 16'hA5A5 (WIDTH bits), pattern seed.
REQ-005 clk_i  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst_i  input  1  synchronous, active-low reset.
REQ-007 start_i  input  1  starts a test run when sampled high in IDLE or DONE.
REQ-008 busy_o  output  1  high while a run is in progress.
REQ-009 done_o  output  1  high in DONE, held until the next start or reset.
REQ-010 pass_o  output  1  run result; meaningful only while done_o=1.
REQ-011 err_count_o  output  ADDR_WIDTH+2  saturating count of read mismatches.
REQ-012 fail_addr_o  output  ADDR_WIDTH  address of the first mismatch.
REQ-013 addr_o  output  ADDR_WIDTH  memory request address.
REQ-014 wdata_o  output  WIDTH  memory write data.
REQ-015 wr_rd_o  output  1  1=write, 0=read.
REQ-016 valid_o  output  1  memory request valid.
REQ-017 ready_i  input  1  memory accepts the request; for reads, rdata_i is valid in the same cycle.
REQ-018 rdata_i  input  WIDTH  memory read data.

Function
REQ-019 A transfer SHALL occur on each rising edge where valid_o=1 and ready_i=1.
REQ-020 While valid_o=1 and ready_i=0, addr_o, wdata_o and wr_rd_o SHALL be held stable.
REQ-021 valid_o SHALL NOT drop before a handshake, except on reset; back-to-back transfers SHALL be supported with no idle cycle.
REQ-022 Pattern P(a) = zero-extended a XOR SEED, truncated to WIDTH bits.
REQ-023 States: IDLE, WR0, RD0, [WR1, RD1], DONE.
REQ-024 IDLE/DONE + start_i -> WR0 with addr_o=0 and valid_o=1 on the next cycle; also clears err_count_o, fail_addr_o and done_o.
REQ-025 WR0: write P(a) for a=0..DEPTH-1 in ascending order; after the handshake at DEPTH-1, go to RD0 with addr 0.
REQ-026 RD0: read a=0..DEPTH-1; compare rdata_i with P(a) at each handshake edge.
REQ-027 On a mismatch, err_count_o SHALL increment, saturating at all-ones; fail_addr_o SHALL be captured only if err_count_o was 0.
REQ-028 After the last read of the final phase, enter DONE, with pass_o = (err_count_o==0) including the final compare.
REQ-029 start_i while busy_o=1 SHALL be ignored.
REQ-030 Address SHALL wrap to 0 at each phase boundary; DEPTH need not be a power of two.
REQ-031 With ready_i held at 1, done_o SHALL rise exactly 2*DEPTH cycles after the start edge (4*DEPTH with REQ-037 enabled).

Reset
REQ-032 While rst_i=0 at a rising edge: state IDLE; valid_o, wr_rd_o, busy_o, done_o, pass_o = 0; addr_o, wdata_o, err_count_o, fail_addr_o = 0.
REQ-033 A reset mid-run SHALL abort immediately, without waiting for an outstanding handshake; valid_o SHALL be 0 from the next cycle.

Configuration
REQ-034 Macro MEM_BIST_INV_PASS_EN SHALL select the inverse-pattern pass.
REQ-035 When MEM_BIST_INV_PASS_EN is defined, RD0 -> WR1 (write ~P(a)) -> RD1 (compare against ~P(a)) -> DONE.
REQ-036 When MEM_BIST_INV_PASS_EN is undefined, RD0 -> DONE, and the WR1/RD1 states SHALL NOT exist.
REQ-037 Inverse-pass timing applies only when MEM_BIST_INV_PASS_EN is defined.

Verification
REQ-038 Ideal memory (ready_i=1), start at edge 0 -> done_o=1 after 128 cycles (256 with macro), pass_o=1, err_count_o=0.
REQ-039 Memory inserting 2 wait cycles per request -> request signals stable during waits, no dropped or duplicated address, pass_o=1.
REQ-040 Bit0 stuck-at-1 at addr 5 (P(5)=16'hA5A0) -> pass_o=0, err_count_o=1, fail_addr_o=5, in both configurations.
REQ-041 rst_i=0 during the WR0 request to addr 20 with ready_i=0 -> next cycle valid_o=0, busy_o=0; a rerun then passes.
REQ-042 start_i pulsed during RD0 -> ignored; completion time unchanged; a second start in DONE clears the results and reruns.
REQ-043 Every address faulty -> err_count_o=64 (128 with macro), no saturation, fail_addr_o=0.
